acc_pack_fifo: RTL and testbench
================================

# acc_pack_fifo

Downstream consumer of the i_clk-domain accumulator output in the multiple-clock sandbox. It decimates the accumulator value by a programmable factor and packs pairs of samples into double-width words. It buffers the words in a small FIFO and presents them on a valid/ready stream for the Verilator harness or a later stage. Overflow is flagged and never silently hidden.

## Interface
- BUS_WIDTH, 4, width of one accumulator sample
- DECIM, 4, sample one value every DECIM enabled cycles (>= 1)
- DEPTH, 4, FIFO depth in packed words (power of 2, >= 2)

- i_clk  input  1  clock; all logic on rising edge
- i_arst_n  input  1  reset, asynchronous, active-low
- i_en  input  1  sampling enable
- i_din  input  BUS_WIDTH  accumulator value to sample
- o_data  output  2*BUS_WIDTH  FIFO head word {newer sample, older sample}
- o_valid  output  1  FIFO non-empty, o_data valid
- i_ready  input  1  consumer accepts o_data this cycle
- o_count  output  $clog2(DEPTH)+1  words currently stored
- o_overflow  output  1  sticky: a completed word was dropped because the FIFO was full
- i_clr_ovf  input  1  clears o_overflow

## Operation
- Decimation counter dcnt runs 0..DECIM-1 while i_en=1 and wraps to 0. While i_en=0 it is forced to 0.
- Strobe is i_en && dcnt==DECIM-1. On a strobe edge, i_din is captured.
- Pack FSM states:
  - LOW_EMPTY: a strobe stores i_din in the low half and moves to HAVE_LOW.
  - HAVE_LOW: a strobe forms the word {i_din, low}, issues a push, and returns to LOW_EMPTY.
- i_en=0 in HAVE_LOW discards the held half and moves to LOW_EMPTY. Only complete pairs are ever pushed.
- FIFO is first-word fall-through, with read/write pointers of $clog2(DEPTH) bits that wrap modulo DEPTH.
- pop = o_valid && i_ready. Popping while empty is impossible, because o_valid=0.
- Push while full:
  - With no pop: the word is dropped, o_overflow is set, and pointers and contents are unchanged.
  - With a simultaneous pop: the push is accepted and o_count stays at DEPTH.
- Push and pop in the same cycle, not full: both happen and o_count is unchanged.
- o_overflow is set on a drop and cleared by i_clr_ovf. If both occur in the same cycle, set wins.
- Arithmetic: o_count spans 0..DEPTH inclusive. Pointer wrap is silent.

## Timing
- Reset values:
  - o_data=0, o_valid=0, o_count=0, o_overflow=0.
  - dcnt=0, FSM=LOW_EMPTY, pointers=0.
- Reset is asynchronous. Assertion mid-operation clears everything immediately, and FIFO contents are considered lost. Deassertion takes effect at the next rising edge.
- With i_en rising before edge k, strobes fall on edges k+DECIM-1, k+2*DECIM-1, and so on.
- Latency:
  - The push happens on the second strobe edge of a pair.
  - o_valid=1 and o_data=word in the cycle following that edge, when the FIFO was empty.
  - o_count is updated in the same cycle.
- Pop: data is consumed on the edge where o_valid && i_ready. The next word, or o_valid=0, appears in the following cycle.
- Throughput: one pop per cycle. Sustained push rate is at most one word per 2*DECIM cycles.
- o_overflow rises in the cycle after the dropping edge.

## Test plan
- **Basic pairing.** DECIM=4, i_ready=1, i_en=1, i_din=3 at the first strobe and 5 at the second → o_valid pulses one cycle with o_data=8'h53, then o_count=0.
- **Overflow and ordering.** i_ready=0, push 5 words (8'h10, 8'h32, 8'h54, 8'h76, 8'h98) → o_count=4, o_overflow=1, 8'h98 absent. Then drain with i_ready=1 → 8'h10, 8'h32, 8'h54, 8'h76 in order.
- **Full with simultaneous pop.** FIFO full, i_ready=1 on the same edge as a push → o_count stays 4, o_overflow stays 0, new word appears after the existing three.
- **Partial pair discard.** One strobe with i_din=7, then i_en=0 for 1 cycle, then two strobes with 1 and 2 → only 8'h21 is produced; 7 never appears.
- **Overflow clear race.** Assert i_clr_ovf on the same edge as a drop → o_overflow=1. Then assert i_clr_ovf alone → o_overflow=0.
- **Reset mid-operation.** 2 words stored and FSM in HAVE_LOW, pull i_arst_n low mid-cycle → all outputs 0 immediately. After release, the next pair is the first word out.

Source files
------------

// File: rtl/acc_pack_fifo.sv
// Decimates the accumulator stream, packs sample pairs into double-width words and queues them in a
// fall-through FIFO. Word visible the cycle after its second strobe; full FIFO without a pop drops and flags overflow.
module acc_pack_fifo #(
   parameter int BUS_WIDTH = 4,
   parameter int DECIM     = 4,
   parameter int DEPTH     = 4
) (
   input  logic                       i_clk,
   input  logic                       i_arst_n,
   input  logic                       i_en,
   input  logic [BUS_WIDTH-1:0]       i_din,
   output logic [2*BUS_WIDTH-1:0]     o_data,
   output logic                       o_valid,
   input  logic                       i_ready,
   output logic [$clog2(DEPTH):0]     o_count,
   output logic                       o_overflow,
   input  logic                       i_clr_ovf
);

   localparam int DCW = (DECIM > 1) ? $clog2(DECIM) : 1;
   localparam int PW  = $clog2(DEPTH);
   localparam int CW  = PW + 1;
   localparam logic [DCW-1:0] DCNT_LAST = DCW'(DECIM - 1);
   localparam logic [CW-1:0]  FULL_CNT  = CW'(DEPTH);

   typedef enum logic {
      LOW_EMPTY = 1'b0,
      HAVE_LOW  = 1'b1
   } state_t;

   logic [DCW-1:0]          r_dcnt;
   logic                    w_strobe;
   state_t                  r_state;
   state_t                  w_state_nxt;
   logic                    w_low_ld;
   logic                    w_push;
   logic [BUS_WIDTH-1:0]    r_low;
   logic [2*BUS_WIDTH-1:0]  w_word;

   logic [2*BUS_WIDTH-1:0]  r_mem [DEPTH];
   logic [PW-1:0]           r_wptr;
   logic [PW-1:0]           r_rptr;
   logic [CW-1:0]           r_count;
   logic                    r_ovf;
   logic                    w_full;
   logic                    w_nonempty;
   logic                    w_pop;
   logic                    w_wr;
   logic                    w_drop;

   // Decimation phase restarts from zero whenever sampling is disabled.
   always_ff @(posedge i_clk or negedge i_arst_n) begin
      if (!i_arst_n) begin
         r_dcnt <= '0;
      end else if (!i_en || (r_dcnt == DCNT_LAST)) begin
         r_dcnt <= '0;
      end else begin
         r_dcnt <= r_dcnt + DCW'(1);
      end
   end

   assign w_strobe = i_en && (r_dcnt == DCNT_LAST);

   always_ff @(posedge i_clk or negedge i_arst_n) begin
      if (!i_arst_n) begin
         r_state <= LOW_EMPTY;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_low_ld    = 1'b0;
      w_push      = 1'b0;
      if (!i_en) begin
         w_state_nxt = LOW_EMPTY;
      end else if (w_strobe) begin
         case (r_state)
            LOW_EMPTY: begin
               w_low_ld    = 1'b1;
               w_state_nxt = HAVE_LOW;
            end
            HAVE_LOW: begin
               w_push      = 1'b1;
               w_state_nxt = LOW_EMPTY;
            end
            default: w_state_nxt = LOW_EMPTY;
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_arst_n) begin
      if (!i_arst_n) begin
         r_low <= '0;
      end else if (w_low_ld) begin
         r_low <= i_din;
      end
   end

   assign w_word     = {i_din, r_low};
   assign w_full     = (r_count == FULL_CNT);
   assign w_nonempty = (r_count != '0);
   assign w_pop      = w_nonempty && i_ready;
   // A full FIFO still accepts a word when the head leaves on the same edge.
   assign w_wr       = w_push && (!w_full || w_pop);
   assign w_drop     = w_push && w_full && !w_pop;

   always_ff @(posedge i_clk) begin
      if (w_wr) begin
         r_mem[r_wptr] <= w_word;
      end
   end

   always_ff @(posedge i_clk or negedge i_arst_n) begin
      if (!i_arst_n) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_wr) begin
            r_wptr <= r_wptr + PW'(1);
         end
         if (w_pop) begin
            r_rptr <= r_rptr + PW'(1);
         end
         case ({w_wr, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // A drop in the same cycle as a clear keeps the flag set.
   always_ff @(posedge i_clk or negedge i_arst_n) begin
      if (!i_arst_n) begin
         r_ovf <= 1'b0;
      end else if (w_drop) begin
         r_ovf <= 1'b1;
      end else if (i_clr_ovf) begin
         r_ovf <= 1'b0;
      end
   end

   assign o_valid    = w_nonempty;
   assign o_data     = w_nonempty ? r_mem[r_rptr] : '0;
   assign o_count    = r_count;
   assign o_overflow = r_ovf;

endmodule

// File: tb/tb_acc_pack_fifo.sv
// Bench for acc_pack_fifo: directed vector table, hand-written corner sequences, then random traffic
// checked against a queue-based reference model.
module tb_acc_pack_fifo;

   localparam int BW = 4;
   localparam int D  = 4;
   localparam int N  = 4;

   logic          i_clk = 1'b0;
   logic          i_arst_n;
   logic          i_en;
   logic [BW-1:0] i_din;
   logic [2*BW-1:0] o_data;
   logic          o_valid;
   logic          i_ready;
   logic [$clog2(N):0] o_count;
   logic          o_overflow;
   logic          i_clr_ovf;

   int n_checks = 0;
   int n_errors = 0;

   acc_pack_fifo #(.BUS_WIDTH(BW), .DECIM(D), .DEPTH(N)) dut (
      .i_clk      (i_clk),
      .i_arst_n   (i_arst_n),
      .i_en       (i_en),
      .i_din      (i_din),
      .o_data     (o_data),
      .o_valid    (o_valid),
      .i_ready    (i_ready),
      .o_count    (o_count),
      .o_overflow (o_overflow),
      .i_clr_ovf  (i_clr_ovf)
   );

   always #5 i_clk = ~i_clk;

   // Reference model: run length of enabled cycles, held half-sample, word queue, sticky flag.
   int              m_run;
   logic [BW-1:0]   m_half[$];
   logic [2*BW-1:0] m_q[$];
   logic            m_ovf;

   task automatic model_reset();
      m_run = 0;
      m_half.delete();
      m_q.delete();
      m_ovf = 1'b0;
   endtask

   task automatic model_edge(input logic en, input logic [BW-1:0] din, input logic rdy, input logic clr);
      logic pop, push, full, drop;
      logic [2*BW-1:0] w;
      pop  = (m_q.size() > 0) && rdy;
      push = 1'b0;
      w    = '0;
      if (en) begin
         if (((m_run + 1) % D) == 0) begin
            if (m_half.size() == 0) begin
               m_half.push_back(din);
            end else begin
               w = {din, m_half[0]};
               m_half.delete();
               push = 1'b1;
            end
         end
         m_run++;
      end else begin
         m_run = 0;
         m_half.delete();
      end
      full = (m_q.size() == N);
      drop = push && full && !pop;
      if (pop) void'(m_q.pop_front());
      if (push && !drop) m_q.push_back(w);
      if (drop) m_ovf = 1'b1;
      else if (clr) m_ovf = 1'b0;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic en, input logic [BW-1:0] din, input logic rdy, input logic clr);
      i_en      = en;
      i_din     = din;
      i_ready   = rdy;
      i_clr_ovf = clr;
      model_edge(en, din, rdy, clr);
      @(posedge i_clk);
      #1;
   endtask

   task automatic push_word(input logic [BW-1:0] lo, input logic [BW-1:0] hi,
                            input logic rdy_last, input logic clr_last);
      for (int i = 0; i < 2 * D; i++)
         drive(1'b1, (i < D) ? lo : hi, (i == 2 * D - 1) ? rdy_last : 1'b0,
               (i == 2 * D - 1) ? clr_last : 1'b0);
   endtask

   task automatic do_reset();
      i_en = 1'b0; i_din = '0; i_ready = 1'b0; i_clr_ovf = 1'b0;
      i_arst_n = 1'b0;
      model_reset();
      #2;
      i_arst_n = 1'b1;
      @(posedge i_clk);
      #1;
   endtask

   task automatic chk_model(input string tag);
      chk({tag, "_valid"}, 32'(o_valid), 32'(m_q.size() > 0));
      chk({tag, "_count"}, 32'(o_count), 32'(m_q.size()));
      chk({tag, "_ovf"}, 32'(o_overflow), 32'(m_ovf));
      if (m_q.size() > 0) chk({tag, "_data"}, 32'(o_data), 32'(m_q[0]));
   endtask

   typedef struct {
      logic          en;
      logic [BW-1:0] din;
      logic          rdy;
      logic          clr;
      logic          vld;
      logic [7:0]    dat;
      logic [2:0]    cnt;
      logic          ovf;
   } vec_t;

   vec_t vecs[$];

   task automatic addv(input logic en, input logic [BW-1:0] din, input logic rdy, input logic clr,
                       input logic vld, input logic [7:0] dat, input logic [2:0] cnt, input logic ovf);
      vec_t v;
      v.en = en; v.din = din; v.rdy = rdy; v.clr = clr;
      v.vld = vld; v.dat = dat; v.cnt = cnt; v.ovf = ovf;
      vecs.push_back(v);
   endtask

   initial begin
      logic [7:0] ord1[4];
      logic [7:0] ord2[4];
      ord1[0] = 8'h10; ord1[1] = 8'h32; ord1[2] = 8'h54; ord1[3] = 8'h76;
      ord2[0] = 8'hD2; ord2[1] = 8'hE3; ord2[2] = 8'hF4; ord2[3] = 8'h5A;

      // Basic pairing: strobes on rows 3 and 7, word visible after row 7, popped on row 8.
      for (int i = 0; i < 4; i++) addv(1, 4'h3, 1, 0, 0, 8'h00, 0, 0);
      for (int i = 0; i < 3; i++) addv(1, 4'h5, 1, 0, 0, 8'h00, 0, 0);
      addv(1, 4'h5, 1, 0, 1, 8'h53, 1, 0);
      addv(0, 4'h0, 1, 0, 0, 8'h00, 0, 0);
      addv(0, 4'h0, 1, 0, 0, 8'h00, 0, 0);
      // Partial pair: 7 held, dropped by one disabled cycle, then 1 and 2 pair up.
      for (int i = 0; i < 4; i++) addv(1, 4'h7, 1, 0, 0, 8'h00, 0, 0);
      addv(0, 4'h7, 1, 0, 0, 8'h00, 0, 0);
      for (int i = 0; i < 4; i++) addv(1, 4'h1, 1, 0, 0, 8'h00, 0, 0);
      for (int i = 0; i < 3; i++) addv(1, 4'h2, 1, 0, 0, 8'h00, 0, 0);
      addv(1, 4'h2, 1, 0, 1, 8'h21, 1, 0);
      addv(0, 4'h0, 1, 0, 0, 8'h00, 0, 0);

      i_en = 1'b0; i_din = '0; i_ready = 1'b0; i_clr_ovf = 1'b0;
      i_arst_n = 1'b0;
      model_reset();
      #12;
      chk("rst_valid", 32'(o_valid), 0);
      chk("rst_data", 32'(o_data), 0);
      chk("rst_count", 32'(o_count), 0);
      chk("rst_ovf", 32'(o_overflow), 0);
      @(negedge i_clk);
      i_arst_n = 1'b1;

      foreach (vecs[k]) begin
         drive(vecs[k].en, vecs[k].din, vecs[k].rdy, vecs[k].clr);
         chk($sformatf("vec%0d_valid", k), 32'(o_valid), 32'(vecs[k].vld));
         chk($sformatf("vec%0d_count", k), 32'(o_count), 32'(vecs[k].cnt));
         chk($sformatf("vec%0d_ovf", k), 32'(o_overflow), 32'(vecs[k].ovf));
         if (vecs[k].vld) chk($sformatf("vec%0d_data", k), 32'(o_data), 32'(vecs[k].dat));
      end

      // Fill, drop with a coincident clear, clear alone, drop again, then drain in order.
      do_reset();
      push_word(4'h0, 4'h1, 0, 0);
      push_word(4'h2, 4'h3, 0, 0);
      push_word(4'h4, 4'h5, 0, 0);
      push_word(4'h6, 4'h7, 0, 0);
      chk("full_count", 32'(o_count), 4);
      chk("full_ovf", 32'(o_overflow), 0);
      chk("full_head", 32'(o_data), 32'h10);
      push_word(4'h8, 4'h9, 0, 1);
      chk("clr_race_ovf", 32'(o_overflow), 1);
      chk("clr_race_count", 32'(o_count), 4);
      drive(0, 4'h0, 0, 1);
      chk("clr_alone_ovf", 32'(o_overflow), 0);
      push_word(4'h8, 4'h9, 0, 0);
      chk("drop_ovf", 32'(o_overflow), 1);
      chk("drop_count", 32'(o_count), 4);
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("drain1_%0d", k), 32'(o_data), 32'(ord1[k]));
         drive(0, 4'h0, 1, 0);
      end
      chk("drain1_valid", 32'(o_valid), 0);
      chk("drain1_count", 32'(o_count), 0);

      // Full FIFO with a pop on the pushing edge.
      drive(0, 4'h0, 0, 1);
      push_word(4'h1, 4'hC, 0, 0);
      push_word(4'h2, 4'hD, 0, 0);
      push_word(4'h3, 4'hE, 0, 0);
      push_word(4'h4, 4'hF, 0, 0);
      push_word(4'hA, 4'h5, 1, 0);
      chk("fullpop_count", 32'(o_count), 4);
      chk("fullpop_ovf", 32'(o_overflow), 0);
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("drain2_%0d", k), 32'(o_data), 32'(ord2[k]));
         drive(0, 4'h0, 1, 0);
      end
      chk("drain2_valid", 32'(o_valid), 0);

      // Reset mid-cycle with two words stored and a half-sample held.
      do_reset();
      push_word(4'h5, 4'h6, 0, 0);
      push_word(4'h7, 4'h8, 0, 0);
      for (int i = 0; i < D; i++) drive(1, 4'h7, 0, 0);
      chk("pre_rst_count", 32'(o_count), 2);
      #3;
      i_arst_n = 1'b0;
      model_reset();
      #1;
      chk("midrst_valid", 32'(o_valid), 0);
      chk("midrst_data", 32'(o_data), 0);
      chk("midrst_count", 32'(o_count), 0);
      chk("midrst_ovf", 32'(o_overflow), 0);
      @(negedge i_clk);
      i_arst_n = 1'b1;
      push_word(4'h3, 4'h4, 0, 0);
      chk("postrst_valid", 32'(o_valid), 1);
      chk("postrst_data", 32'(o_data), 32'h43);
      chk("postrst_count", 32'(o_count), 1);

      // Random traffic against the model; readiness level varies by block to reach full and overflow.
      do_reset();
      for (int c = 0; c < 2400; c++) begin
         int lvl;
         lvl = (c / 200) % 4;
         drive(1'($urandom_range(0, 15) != 0), 4'($urandom),
               1'($urandom_range(0, 3) < lvl), 1'($urandom_range(0, 15) == 0));
         chk_model("rnd");
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
